// File: rtl/mem_ctrl_pkg.sv
// Shared types, defaults and helpers for the burst memory controller family.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        RD_ISSUE = 2'd2,
        RD_DRAIN = 2'd3
    } state_t;

    localparam int                        DEFAULT_DATA_W = 16;
    localparam int                        DEFAULT_PAGE_W = 4;
    localparam logic [DEFAULT_PAGE_W-1:0] DEFAULT_PAGE   = 4'h2;

    // Width of a beat index; never below one bit so a single-beat burst still has a counter.
    function automatic int beat_w(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Burst address generator: holds the burst base and a beat offset and forms
// either an incrementing (page-wrapping) or a block-wrapping word address.
module burst_addr_gen
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int BURST_LEN  = 4,
    parameter bit WRAP_BURST = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr
);

    localparam int BEAT_W = beat_w(BURST_LEN);
    localparam int LOW_W  = $clog2(BURST_LEN);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [BEAT_W-1:0] offset_q, offset_d;

    // A load captures a fresh base and restarts at beat zero; advance steps one beat.
    always_comb begin
        base_d   = base_q;
        offset_d = offset_q;
        if (load) begin
            base_d   = base;
            offset_d = '0;
        end else if (advance) begin
            offset_d = offset_q + BEAT_W'(1);
        end
    end

    // Base and offset registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q   <= '0;
            offset_q <= '0;
        end else begin
            base_q   <= base_d;
            offset_q <= offset_d;
        end
    end

    generate
        if (!WRAP_BURST) begin : g_incr
            // The sum is truncated to ADDR_W, so the address rolls over at the page top.
            assign addr = base_q + ADDR_W'(offset_q);
        end else if (LOW_W == 0) begin : g_single
            assign addr = base_q;
        end else begin : g_wrap
            // Only the low bits move; the BURST_LEN-aligned block stays fixed.
            logic [LOW_W-1:0] low_sum;
            assign low_sum = base_q[LOW_W-1:0] + offset_q[LOW_W-1:0];
            assign addr    = {base_q[ADDR_W-1:LOW_W], low_sum};
        end
    endgenerate

endmodule

// File: rtl/burst_mem_controller.sv
// Burst memory controller: decodes a page on the multiplexed CPU bus and runs
// fixed-length write or read bursts against a synchronous single-port memory.
module burst_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int                DATA_W     = DEFAULT_DATA_W,
    parameter int                PAGE_W     = DEFAULT_PAGE_W,
    parameter logic [PAGE_W-1:0] PAGE       = PAGE_W'(DEFAULT_PAGE),
    parameter int                BURST_LEN  = 4,
    parameter int                RD_LATENCY = 1,
    parameter bit                WRAP_BURST = 1'b0,
    localparam int               ADDR_W     = DATA_W - PAGE_W
) (
    input  logic              clk,
    input  logic              resetH,
    inout  tri   [DATA_W-1:0] AddrData,
    input  logic              AddrValid,
    input  logic              rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              proto_err
);

    // Five bits cover both the longest burst (16 beats) and the longest drain.
    localparam int               CNT_W      = 5;
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(RD_LATENCY - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        beat_q, beat_d;
    logic [RD_LATENCY-1:0]   drive_q, drive_d;
    logic                    drive_en;
    logic                    page_hit;
    logic                    gen_load;
    logic                    gen_advance;
    logic [ADDR_W-1:0]       gen_addr;

    assign page_hit  = (AddrData[DATA_W-1 -: PAGE_W] == PAGE);
    assign drive_en  = drive_q[RD_LATENCY-1];
    assign busy      = (state_q != IDLE);
    assign proto_err = AddrValid && busy;
    assign mem_wdata = AddrData;
    assign AddrData  = drive_en ? mem_rdata : {DATA_W{1'bz}};

    burst_addr_gen #(
        .ADDR_W     (ADDR_W),
        .BURST_LEN  (BURST_LEN),
        .WRAP_BURST (WRAP_BURST)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (resetH),
        .load    (gen_load),
        .base    (AddrData[ADDR_W-1:0]),
        .advance (gen_advance),
        .addr    (gen_addr)
    );

    // Next-state and strobe logic; addresses are only presented during beats.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = '0;
        gen_load    = 1'b0;
        gen_advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (AddrValid && page_hit) begin
                    gen_load = 1'b1;
                    beat_d   = '0;
                    state_d  = rw ? RD_ISSUE : WRITE;
                end
            end
            WRITE: begin
                mem_we      = 1'b1;
                mem_addr    = gen_addr;
                gen_advance = 1'b1;
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + CNT_W'(1);
                end
            end
            RD_ISSUE: begin
                mem_re      = 1'b1;
                mem_addr    = gen_addr;
                gen_advance = 1'b1;
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = RD_DRAIN;
                end else begin
                    beat_d = beat_q + CNT_W'(1);
                end
            end
            RD_DRAIN: begin
                if (beat_q == LAST_DRAIN) begin
                    beat_d  = '0;
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    generate
        if (RD_LATENCY == 1) begin : g_drv_one
            // With a one-cycle memory the bus is driven the cycle after each read strobe.
            always_comb drive_d = mem_re;
        end else begin : g_drv_multi
            // Delay each read strobe by the memory latency so drive lines up with valid data.
            always_comb drive_d = {drive_q[RD_LATENCY-2:0], mem_re};
        end
    endgenerate

    // State, beat counter and bus-drive pipeline; reset aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (resetH) begin
            state_q <= IDLE;
            beat_q  <= '0;
            drive_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            drive_q <= drive_d;
        end
    end

endmodule

// File: tb/tb_burst_mem_controller.sv
// Bench for burst_mem_controller: three configurations (default, wrapping burst,
// long burst with slow memory) share one clock and reset and are checked against
// a transaction-level model of addresses, strobes, bus drive and memory contents.
`timescale 1ns/1ps
module tb_burst_mem_controller;
    import mem_ctrl_pkg::*;

    localparam int NDUT = 3;

    typedef struct {
        int          g;
        bit          rw;
        logic [15:0] addr;
        bit          accept;
        logic [11:0] a0;
        logic [11:0] a2;
    } vec_t;

    logic                       clk = 1'b0;
    logic                       resetH;
    logic [NDUT-1:0]            av;
    logic [NDUT-1:0]            rw_v;
    logic [NDUT-1:0]            cpu_oe;
    logic [NDUT-1:0][15:0]      cpu_val;
    logic [NDUT-1:0]            o_we, o_re, o_busy, o_perr;
    logic [NDUT-1:0][11:0]      o_addr;
    logic [NDUT-1:0][15:0]      o_wdata, o_bus;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] ref_mem [NDUT][4096];
    vec_t        vecs [11];
    logic [11:0] a0, a2;
    bit          seen;
    int          rg, pc;
    bit          rrw;
    logic [3:0]  pg;
    logic [15:0] rad;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int BL = (g == 2) ? 8 : 4;
        localparam int RL = (g == 2) ? 3 : 1;
        localparam bit WB = (g == 1);

        tri0  [15:0] bus;
        logic [11:0] mem_addr;
        logic [15:0] mem_wdata, mem_rdata;
        logic        mem_we, mem_re, busy, proto_err;
        logic [15:0] store [4096];
        logic [15:0] rd_pipe [RL];

        // Memory starts with a recognisable non-zero pattern.
        initial for (int a = 0; a < 4096; a++) store[a] = 16'(a) ^ 16'h5A5A;

        // Synchronous memory: writes on the edge, reads appear RL cycles after the strobe.
        always @(posedge clk) begin
            if (mem_we) store[mem_addr] <= mem_wdata;
            rd_pipe[0] <= mem_re ? store[mem_addr] : 16'hDEAD;
            for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
        end

        assign mem_rdata = rd_pipe[RL-1];
        assign bus       = cpu_oe[g] ? cpu_val[g] : 16'hzzzz;

        burst_mem_controller #(
            .DATA_W     (16),
            .PAGE_W     (4),
            .PAGE       (4'h2),
            .BURST_LEN  (BL),
            .RD_LATENCY (RL),
            .WRAP_BURST (WB)
        ) u_dut (
            .clk       (clk),
            .resetH    (resetH),
            .AddrData  (bus),
            .AddrValid (av[g]),
            .rw        (rw_v[g]),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_we    (mem_we),
            .mem_re    (mem_re),
            .mem_rdata (mem_rdata),
            .busy      (busy),
            .proto_err (proto_err)
        );

        assign o_we[g]    = mem_we;
        assign o_re[g]    = mem_re;
        assign o_busy[g]  = busy;
        assign o_perr[g]  = proto_err;
        assign o_addr[g]  = mem_addr;
        assign o_wdata[g] = mem_wdata;
        assign o_bus[g]   = bus;
    end

    function automatic int blOf(input int g);
        return (g == 2) ? 8 : 4;
    endfunction

    function automatic int rlOf(input int g);
        return (g == 2) ? 3 : 1;
    endfunction

    function automatic bit wrapOf(input int g);
        return (g == 1);
    endfunction

    // Address of beat i, straight from the burst rules: page-wrapping increment,
    // or rotation inside the BURST_LEN-aligned block.
    function automatic logic [11:0] beatAddr(input int g, input logic [11:0] base, input int i);
        int bl, b;
        bl = blOf(g);
        b  = int'(base);
        if (wrapOf(g)) return 12'((b - (b % bl)) + ((b + i) % bl));
        return 12'((b + i) % 4096);
    endfunction

    // One comparison; counts it and reports a mismatch.
    task automatic checkOutput(input string name, input int g, input int step,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d step %0d: got 0x%0h, expected 0x%0h",
                     name, g, step, act, exp);
        end
    endtask

    // Runs one transaction on DUT g, cycle 0 being the AddrValid cycle, and checks
    // every cycle against the model. perr_cyc/rst_cyc (0 = none) inject a stray
    // AddrValid or a reset in that cycle. Returns beat 0 and beat 2 addresses seen.
    task automatic applyStimulus(input int g, input bit rw, input logic [15:0] addr,
                                 input int perr_cyc, input int rst_cyc,
                                 output logic [11:0] obs_a0, output logic [11:0] obs_a2,
                                 output bit obs_seen);
        int          bl, rl, last;
        bit          accept;
        logic [15:0] wd [16];
        bl     = blOf(g);
        rl     = rlOf(g);
        accept = (addr[15:12] == 4'h2);
        last   = !accept ? 2 : (rw ? bl + rl : bl);
        if (rst_cyc != 0) last = rst_cyc + 1;
        for (int i = 0; i < 16; i++) wd[i] = 16'($urandom_range(1, 65535));
        obs_seen = 1'b0;
        obs_a0   = '0;
        obs_a2   = '0;
        for (int c = 0; c <= last; c++) begin
            bit          alive, exp_we, exp_re, exp_busy, exp_drv, exp_perr, bench_drv;
            logic [11:0] ea;
            @(posedge clk);
            #1;
            resetH    = (rst_cyc != 0) && (c == rst_cyc);
            av        = '0;
            cpu_oe    = '0;
            av[g]     = (c == 0) || (perr_cyc != 0 && c == perr_cyc);
            rw_v[g]   = rw;
            bench_drv = (c == 0) || (!rw && accept && c <= bl);
            cpu_oe[g] = bench_drv;
            cpu_val[g] = (c == 0) ? addr : (bench_drv ? wd[c-1] : 16'h0000);

            alive    = accept && c >= 1 && (rst_cyc == 0 || c <= rst_cyc);
            exp_we   = alive && !rw && c <= bl;
            exp_re   = alive && rw && c <= bl;
            exp_busy = alive && c <= (rw ? bl + rl : bl);
            exp_drv  = alive && rw && c >= 1 + rl && c <= bl + rl;
            exp_perr = (perr_cyc != 0) && (c == perr_cyc) && exp_busy;

            @(negedge clk);
            obs_seen = obs_seen | o_we[g] | o_re[g];
            if (c == 1) obs_a0 = o_addr[g];
            if (c == 3) obs_a2 = o_addr[g];
            checkOutput("busy", g, c, 32'(o_busy[g]), 32'(exp_busy));
            checkOutput("mem_we", g, c, 32'(o_we[g]), 32'(exp_we));
            checkOutput("mem_re", g, c, 32'(o_re[g]), 32'(exp_re));
            checkOutput("proto_err", g, c, 32'(o_perr[g]), 32'(exp_perr));
            if (exp_we || exp_re) begin
                ea = beatAddr(g, addr[11:0], c - 1);
                checkOutput("mem_addr", g, c, 32'(o_addr[g]), 32'(ea));
                if (exp_we) begin
                    checkOutput("mem_wdata", g, c, 32'(o_wdata[g]), 32'(wd[c-1]));
                    ref_mem[g][ea] = wd[c-1];
                end
            end
            if (!bench_drv) begin
                checkOutput("AddrData", g, c, 32'(o_bus[g]),
                            exp_drv ? 32'(ref_mem[g][beatAddr(g, addr[11:0], c - 1 - rl)])
                                    : 32'h0);
            end
        end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset state, vector table, corner cases, random traffic.
    initial begin
        resetH  = 1'b1;
        av      = '0;
        rw_v    = '0;
        cpu_oe  = '0;
        cpu_val = '0;
        for (int g = 0; g < NDUT; g++)
            for (int a = 0; a < 4096; a++) ref_mem[g][a] = 16'(a) ^ 16'h5A5A;

        vecs[0]  = '{0, 1'b0, 16'h2010, 1'b1, 12'h010, 12'h012};
        vecs[1]  = '{0, 1'b1, 16'h2010, 1'b1, 12'h010, 12'h012};
        vecs[2]  = '{0, 1'b0, 16'h3010, 1'b0, 12'h000, 12'h000};
        vecs[3]  = '{0, 1'b1, 16'h3010, 1'b0, 12'h000, 12'h000};
        vecs[4]  = '{0, 1'b0, 16'h2FFE, 1'b1, 12'hFFE, 12'h000};
        vecs[5]  = '{0, 1'b1, 16'h2FFE, 1'b1, 12'hFFE, 12'h000};
        vecs[6]  = '{1, 1'b0, 16'h201E, 1'b1, 12'h01E, 12'h01C};
        vecs[7]  = '{1, 1'b1, 16'h201E, 1'b1, 12'h01E, 12'h01C};
        vecs[8]  = '{2, 1'b1, 16'h2000, 1'b1, 12'h000, 12'h002};
        vecs[9]  = '{2, 1'b0, 16'h2000, 1'b1, 12'h000, 12'h002};
        vecs[10] = '{2, 1'b1, 16'h2000, 1'b1, 12'h000, 12'h002};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            checkOutput("rst_busy", g, 0, 32'(o_busy[g]), 32'h0);
            checkOutput("rst_we", g, 0, 32'(o_we[g]), 32'h0);
            checkOutput("rst_re", g, 0, 32'(o_re[g]), 32'h0);
            checkOutput("rst_perr", g, 0, 32'(o_perr[g]), 32'h0);
            checkOutput("rst_addr", g, 0, 32'(o_addr[g]), 32'h0);
            checkOutput("rst_bus", g, 0, 32'(o_bus[g]), 32'h0);
        end
        @(posedge clk);
        #1;
        resetH = 1'b0;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].g, vecs[i].rw, vecs[i].addr, 0, 0, a0, a2, seen);
            checkOutput("tbl_accept", vecs[i].g, i, 32'(seen), 32'(vecs[i].accept));
            if (vecs[i].accept) begin
                checkOutput("tbl_addr0", vecs[i].g, i, 32'(a0), 32'(vecs[i].a0));
                checkOutput("tbl_addr2", vecs[i].g, i, 32'(a2), 32'(vecs[i].a2));
            end
        end

        $display("[TB] stray AddrValid during bursts");
        applyStimulus(0, 1'b0, 16'h2030, 2, 0, a0, a2, seen);
        applyStimulus(0, 1'b1, 16'h2030, 0, 0, a0, a2, seen);
        applyStimulus(2, 1'b1, 16'h2100, 9, 0, a0, a2, seen);

        $display("[TB] reset in the middle of a read burst");
        applyStimulus(0, 1'b1, 16'h2040, 0, 2, a0, a2, seen);
        applyStimulus(0, 1'b0, 16'h2020, 0, 0, a0, a2, seen);
        applyStimulus(0, 1'b1, 16'h2020, 0, 0, a0, a2, seen);
        checkOutput("post_rst_addr0", 0, 0, 32'(a0), 32'h020);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 30; n++) begin
            rg  = $urandom_range(0, 2);
            rrw = 1'($urandom_range(0, 1));
            pg  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'h2;
            rad = {pg, 12'($urandom_range(0, 4095))};
            pc  = 0;
            if (pg == 4'h2 && $urandom_range(0, 3) == 0)
                pc = $urandom_range(1, rrw ? blOf(rg) + rlOf(rg) : blOf(rg));
            applyStimulus(rg, rrw, rad, pc, 0, a0, a2, seen);
            checkOutput("rnd_accept", rg, n, 32'(seen), 32'(pg == 4'h2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/burst_mem_controller.md
# burst_mem_controller

Parametrised successor to the single-page, fixed-burst memory controller. Sits between the CPU-side multiplexed address/data bus and a synchronous single-port memory. Decodes a page field and runs burst reads and writes of configurable width, length and read latency, with incrementing or wrapping (critical-word-first) burst addressing. Flags protocol violations.

## Interface
- DATA_W, 16: width of AddrData and of memory data.
- PAGE_W, 4: width of the page field, AddrData[DATA_W-1 -: PAGE_W].
- PAGE, 4'h2: page this controller responds to; PAGE_W bits wide.
- BURST_LEN, 4: beats per transaction; must be a power of two, range 1..16.
- RD_LATENCY, 1: memory read latency in cycles, from mem_re to valid mem_rdata; range 1..3.
- WRAP_BURST, 0: 0 = incrementing burst; 1 = burst wraps inside a BURST_LEN-aligned block.
- ADDR_W (local) = DATA_W-PAGE_W.

Ports:
- clk  in  1: single clock for controller and memory; all logic on the rising edge.
- resetH  in  1: synchronous, active-high reset.
- AddrData  inout tri  DATA_W: multiplexed bus. CPU drives the address, then write data. Controller drives read data only.
- AddrValid  in  1: high for one cycle when a valid address is on AddrData.
- rw  in  1: 1 = read, 0 = write. Sampled with AddrValid.
- mem_addr  out  ADDR_W: memory word address.
- mem_wdata  out  DATA_W: write data, combinationally equal to AddrData during write beats.
- mem_we  out  1: memory write strobe.
- mem_re  out  1: memory read strobe.
- mem_rdata  in  DATA_W: memory read data, valid RD_LATENCY cycles after mem_re.
- busy  out  1: a transaction is in progress.
- proto_err  out  1: one-cycle pulse when AddrValid is high while busy.

## Operation
- States: IDLE, WRITE, RD_ISSUE, RD_DRAIN.
- In IDLE with AddrValid=1, the controller compares the page field with PAGE.
  - Page mismatch: stay in IDLE, no strobes, bus not driven.
  - Page match: latch base = AddrData[ADDR_W-1:0], clear the beat counter, and go to WRITE (rw=0) or RD_ISSUE (rw=1).
- WRITE: lasts BURST_LEN cycles.
  - Each cycle: mem_we=1, mem_addr = addr(i), mem_wdata = AddrData.
  - After the last beat, return to IDLE.
- RD_ISSUE: lasts BURST_LEN cycles with mem_re=1 and mem_addr = addr(i). Then go to RD_DRAIN.
- RD_DRAIN: lasts RD_LATENCY cycles, then return to IDLE.
- Bus drive: an RD_LATENCY-deep shift register of mem_re forms drive_en.
  - AddrData = drive_en ? mem_rdata : 'z.
- Address generation, for i = 0..BURST_LEN-1:
  - WRAP_BURST=0: addr(i) = (base+i) mod 2^ADDR_W. The address wraps at the top of the page and never carries into the page field.
  - WRAP_BURST=1: the low log2(BURST_LEN) bits are (base+i) mod BURST_LEN; the upper bits stay equal to base.
- AddrValid while busy is ignored. The transaction continues and proto_err pulses in that cycle.
- A synchronous reset mid-transaction returns the controller to IDLE at the next edge, clears the counters and the drive_en pipeline, and aborts any remaining beats.
- Reset values: all state bits IDLE, busy=0, proto_err=0, mem_we=0, mem_re=0, mem_addr=0, AddrData released (Z).

## Timing
- Cycle 0 is the AddrValid cycle.
- Write beats occur in cycles 1..BURST_LEN, and the memory captures each beat on that cycle's closing edge.
- Read strobes occur in cycles 1..BURST_LEN. Data is driven in cycles 1+RD_LATENCY..BURST_LEN+RD_LATENCY.
- Cycle 1 of a read is never driven, which gives a turnaround cycle after the CPU releases the bus.
- busy is high from cycle 1 through the last beat (write: BURST_LEN; read: BURST_LEN+RD_LATENCY).
- A new AddrValid is accepted in the cycle after busy falls, so back-to-back transactions have no dead cycle.
- No combinational path from AddrValid to busy.

## Structure
- Package mem_ctrl_pkg holds:
  - the state_t enum;
  - helper function clog2-based BEAT_W;
  - the default PAGE/DATA_W constants shared with the memory model and the bench.
- Sub-module burst_addr_gen, parametrised by ADDR_W, BURST_LEN and WRAP_BURST:
  - inputs: load, base, advance;
  - output: addr.
- The FSM, drive_en pipeline and tristate stay in the top module.

## Test plan
All scenarios use defaults PAGE=2, BURST_LEN=4, RD_LATENCY=1 unless stated.
- Write: AddrValid, rw=0, address 0x2010, then data 0xA1,0xB2,0xC3,0xD4 -> mem_we in cycles 1-4 at addresses 0x010-0x013. Read-back returns the same data on AddrData in cycles 2-5, and busy is high for cycles 1-5.
- Page mismatch: AddrValid with address 0x3010 (both rw values) -> no mem_we or mem_re, AddrData stays Z, busy stays 0.
- Page-top wrap: incrementing burst at 0x2FFE -> addresses 0xFFE, 0xFFF, 0x000, 0x001. WRAP_BURST=1 at 0x201E -> 0x01E, 0x01F, 0x01C, 0x01D.
- Latency and length sweep: RD_LATENCY=3 with BURST_LEN=8, read at 0x2000 -> data in cycles 4-11 and busy falls after cycle 11. A back-to-back write accepted in cycle 12 completes correctly.
- Protocol error: AddrValid in cycle 2 of a write -> proto_err high for exactly that cycle, and the original burst completes unchanged.
- Reset during the RD_ISSUE beat in cycle 2 -> next cycle IDLE, AddrData Z, no further mem_re. A following write to 0x2020 succeeds.
